// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-style control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes and per-class datapath selects.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode parks the FSM in TRAP
// until reset; otherwise an illegal opcode retires as a NOP).
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       branch_taken,
  output logic       imem_req,
  output logic       ir_write,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       retire,
  output logic       trap,
  output logic [2:0] state
);

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CLS_W   = 4;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [CLS_W-1:0] {
    CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_ILLEGAL
  } cls_t;

  // Immediate format codes for the immediate generator
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  state_t state_q, state_d;
  cls_t   cls_q, dec_cls;
  logic   run_q;

  // Map a raw opcode to its instruction class
  function automatic cls_t classify(input logic [OPC_W-1:0] op);
    cls_t c;
    case (op)
      OPC_OP:     c = CL_OP;
      OPC_OPIMM:  c = CL_OPIMM;
      OPC_LOAD:   c = CL_LOAD;
      OPC_STORE:  c = CL_STORE;
      OPC_BRANCH: c = CL_BRANCH;
      OPC_LUI:    c = CL_LUI;
      OPC_AUIPC:  c = CL_AUIPC;
      OPC_JAL:    c = CL_JAL;
      OPC_JALR:   c = CL_JALR;
      default:    c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

  // Immediate format required by each class (OP and illegal use 0)
  function automatic logic [2:0] imm_of(input cls_t c);
    logic [2:0] f;
    case (c)
      CL_LOAD, CL_JALR, CL_OPIMM: f = IMM_I;
      CL_STORE:                   f = IMM_S;
      CL_BRANCH:                  f = IMM_B;
      CL_LUI, CL_AUIPC:           f = IMM_U;
      CL_JAL:                     f = IMM_J;
      default:                    f = 3'd0;
    endcase
    return f;
  endfunction

  assign dec_cls = classify(opcode);

  // State, run flag and latched opcode class
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      cls_q   <= CL_ILLEGAL;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == S_DECODE) cls_q <= dec_cls;
    end
  end

  // Next-state and control decode from current state and class
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    imm_sel   = 3'd0;
    alu_src_a = 2'd0;
    alu_src_b = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    case (state_q)
      S_FETCH: begin
        imem_req = run_q;
        if (run_q && imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_sel = imm_of(dec_cls);
        if (dec_cls == CL_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d  = S_FETCH;
          pc_write = 1'b1;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        imm_sel = imm_of(cls_q);
        case (cls_q)
          CL_LUI:   begin alu_src_a = 2'd2; alu_src_b = 1'b1; end
          CL_AUIPC: begin alu_src_a = 2'd1; alu_src_b = 1'b1; end
          CL_OP:    begin alu_src_a = 2'd0; alu_src_b = 1'b0; end
          default:  begin alu_src_a = 2'd0; alu_src_b = 1'b1; end
        endcase
        case (cls_q)
          CL_LOAD, CL_STORE: state_d = S_MEM;
          CL_BRANCH: begin
            state_d  = S_FETCH;
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'd1 : 2'd0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        imm_sel  = imm_of(cls_q);
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_STORE);
        if (dmem_ready) begin
          if (cls_q == CL_STORE) begin
            state_d  = S_FETCH;
            pc_write = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        imm_sel   = imm_of(cls_q);
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        case (cls_q)
          CL_LOAD: wb_sel = 2'd1;
          CL_JAL:  begin wb_sel = 2'd2; pc_src = 2'd1; end
          CL_JALR: begin wb_sel = 2'd2; pc_src = 2'd2; end
          default: wb_sel = 2'd0;
        endcase
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign retire = pc_write;
  assign state  = state_q;

  // Sticky illegal-opcode flag: TRAP is only left through reset
`ifdef ILLEGAL_TRAP_EN
  assign trap = (state_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       imem_ready, dmem_ready, branch_taken;
  logic       imem_req, ir_write;
  logic [2:0] imm_sel;
  logic [1:0] alu_src_a;
  logic       alu_src_b, dmem_req, dmem_we, reg_write;
  logic [1:0] wb_sel;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       retire, trap;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_write(ir_write), .imm_sel(imm_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write(reg_write), .wb_sel(wb_sel),
    .pc_write(pc_write), .pc_src(pc_src),
    .retire(retire), .trap(trap), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, imem_req, ir_write, imm_sel, a, b, dmem_req, dmem_we, reg_write, wb_sel, pc_write, pc_src, retire, trap}
  logic [20:0] outs;
  assign outs = {state, imem_req, ir_write, imm_sel, alu_src_a, alu_src_b,
                 dmem_req, dmem_we, reg_write, wb_sel, pc_write, pc_src, retire, trap};

  typedef struct {
    logic [6:0]  op;
    logic        ir;
    logic        dr;
    logic        bt;
    logic [20:0] exp;
  } vec_t;

  // Build one vector; retire is expected to mirror pc_write, trap low
  function automatic vec_t mk(input int op, input int ir, input int dr, input int bt,
                              input int st, input int imreq, input int irw, input int imm,
                              input int a, input int b, input int dreq, input int dwe,
                              input int rw, input int wb, input int pcw, input int pcs);
    vec_t v;
    v.op  = 7'(op);
    v.ir  = 1'(ir);
    v.dr  = 1'(dr);
    v.bt  = 1'(bt);
    v.exp = {3'(st), 1'(imreq), 1'(irw), 3'(imm), 2'(a), 1'(b), 1'(dreq), 1'(dwe),
             1'(rw), 2'(wb), 1'(pcw), 2'(pcs), 1'(pcw), 1'b0};
    return v;
  endfunction

  task automatic check(input string name, input logic [20:0] exp);
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
               name, outs, exp, state, exp[20:18]);
    end
  endtask

  // Apply inputs on the falling edge, settle before the next rising edge
  task automatic step(input int op, input int ir, input int dr, input int bt);
    @(negedge clk);
    opcode       = 7'(op);
    imem_ready   = 1'(ir);
    dmem_ready   = 1'(dr);
    branch_taken = 1'(bt);
    #4;
  endtask

  vec_t vq[$];
  vec_t v;

  initial begin
    rst_n = 1'b0; opcode = 7'h13; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;

    // OP-IMM
    vq.push_back(mk('h13,1,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h13,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h13,0,0,0, 2,0,0,0, 0,1,0,0,0,0,0,0));
    vq.push_back(mk('h13,0,0,0, 4,0,0,0, 0,0,0,0,1,0,1,0));
    // LOAD: one imem wait, dmem_ready delayed 3 cycles
    vq.push_back(mk('h03,0,0,0, 0,1,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h03,1,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h03,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h03,0,0,0, 2,0,0,0, 0,1,0,0,0,0,0,0));
    vq.push_back(mk('h03,0,0,0, 3,0,0,0, 0,0,1,0,0,0,0,0));
    vq.push_back(mk('h03,0,0,0, 3,0,0,0, 0,0,1,0,0,0,0,0));
    vq.push_back(mk('h03,0,0,0, 3,0,0,0, 0,0,1,0,0,0,0,0));
    vq.push_back(mk('h03,0,1,0, 3,0,0,0, 0,0,1,0,0,0,0,0));
    vq.push_back(mk('h03,0,0,0, 4,0,0,0, 0,0,0,0,1,1,1,0));
    // STORE, dmem_ready high throughout (ignored until MEM)
    vq.push_back(mk('h23,1,1,0, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h23,0,1,0, 1,0,0,1, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h23,0,1,0, 2,0,0,1, 0,1,0,0,0,0,0,0));
    vq.push_back(mk('h23,0,1,0, 3,0,0,1, 0,0,1,1,0,0,1,0));
    // BRANCH taken, then not taken
    vq.push_back(mk('h63,1,0,1, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h63,0,0,1, 1,0,0,2, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h63,0,0,1, 2,0,0,2, 0,1,0,0,0,0,1,1));
    vq.push_back(mk('h63,1,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h63,0,0,0, 1,0,0,2, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h63,0,0,0, 2,0,0,2, 0,1,0,0,0,0,1,0));
    // JAL; opcode bus scrambled after DECODE to exercise the latched class
    vq.push_back(mk('h6F,1,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h6F,0,0,0, 1,0,0,4, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h00,0,0,0, 2,0,0,4, 0,1,0,0,0,0,0,0));
    vq.push_back(mk('h00,0,0,0, 4,0,0,4, 0,0,0,0,1,2,1,1));
    // JALR
    vq.push_back(mk('h67,1,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h67,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h67,0,0,0, 2,0,0,0, 0,1,0,0,0,0,0,0));
    vq.push_back(mk('h67,0,0,0, 4,0,0,0, 0,0,0,0,1,2,1,2));
    // LUI
    vq.push_back(mk('h37,1,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h37,0,0,0, 1,0,0,3, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h37,0,0,0, 2,0,0,3, 2,1,0,0,0,0,0,0));
    vq.push_back(mk('h37,0,0,0, 4,0,0,3, 0,0,0,0,1,0,1,0));
    // AUIPC
    vq.push_back(mk('h17,1,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h17,0,0,0, 1,0,0,3, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h17,0,0,0, 2,0,0,3, 1,1,0,0,0,0,0,0));
    vq.push_back(mk('h17,0,0,0, 4,0,0,3, 0,0,0,0,1,0,1,0));
    // OP
    vq.push_back(mk('h33,1,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h33,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h33,0,0,0, 2,0,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk('h33,0,0,0, 4,0,0,0, 0,0,0,0,1,0,1,0));

    // Reset holds everything quiet even with ready inputs high
    #2;
    check("reset_idle", 21'h0);
    @(negedge clk); #4;
    check("reset_idle2", 21'h0);

    // Release: no fetch request before the first rising edge
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b0;
    #4;
    check("release_no_req", 21'h0);

    foreach (vq[i]) begin
      v = vq[i];
      step(int'(v.op), int'(v.ir), int'(v.dr), int'(v.bt));
      check($sformatf("vec%0d", i), v.exp);
    end

    // Illegal opcode 0x7F
    step('h7F,1,0,0);
    check("ill_fetch", mk(0,0,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0).exp);
    step('h7F,0,0,0);
`ifdef ILLEGAL_TRAP_EN
    check("ill_decode", mk(0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0,0).exp);
    for (int k = 0; k < 20; k++) begin
      step('h7F,1,1,1);
      check($sformatf("trap_hold%0d", k), {3'd5, 17'd0, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("trap_cleared", 21'h0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    check("ill_decode_nop", mk(0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,1,0).exp);
    step('h13,0,0,0);
    check("ill_back_fetch", mk(0,0,0,0, 0,1,0,0, 0,0,0,0,0,0,0,0).exp);
`endif

    // Reset pulse in MEM aborts the access asynchronously
    step('h03,1,0,0);
    check("abort_fetch", mk(0,0,0,0, 0,1,1,0, 0,0,0,0,0,0,0,0).exp);
    step('h03,0,0,0);
    step('h03,0,0,0);
    step('h03,0,0,0);
    check("abort_in_mem", mk(0,0,0,0, 3,0,0,0, 0,0,1,0,0,0,0,0).exp);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_async", 21'h0);
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b0;
    #4;
    check("abort_release_gated", 21'h0);
    @(posedge clk); #1;
    check("abort_req_rises", mk(0,0,0,0, 0,1,0,0, 0,0,0,0,0,0,0,0).exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register.
REQ-005 imem_ready  input  1  instruction memory returns the word this cycle.
REQ-006 dmem_ready  input  1  data memory access completes this cycle.
REQ-007 branch_taken  input  1  branch compare result from the ALU, valid in EXEC.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 ir_write  output  1  load the instruction register.
REQ-010 imm_sel  output  3  immediate format for the immediate generator: 0=I, 1=S, 2=B, 3=U, 4=J.
REQ-011 alu_src_a / alu_src_b  output  2 / 1  A: 0=rs1, 1=PC, 2=zero; B: 0=rs2, 1=imm.
REQ-012 dmem_req / dmem_we  output  1 / 1  data access request and write enable.
REQ-013 reg_write / wb_sel  output  1 / 2  register write enable; write-back source: 0=ALU, 1=mem, 2=PC+4.
REQ-014 pc_write / pc_src  output  1 / 2  PC update strobe; next PC: 0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1.
REQ-015 retire  output  1  one-cycle pulse per completed instruction (equal to pc_write).
REQ-016 trap  output  1  sticky illegal-opcode flag.
REQ-017 state  output  3  current FSM state, for debug.

Function
REQ-018 State encoding is FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; all control outputs are decoded from the current state and the latched opcode class.
REQ-019 In FETCH, imem_req is held at 1 until imem_ready is seen; on that cycle ir_write=1 and the next state is DECODE.
REQ-020 imem_ready and dmem_ready are ignored whenever the matching request is 0.
REQ-021 DECODE lasts one cycle, latches the opcode class, and drives imm_sel: LOAD/JALR/OP-IMM=I, STORE=S, BRANCH=B, LUI/AUIPC=U, JAL=J, OP=0.
REQ-022 From DECODE, a legal opcode goes to EXEC; an illegal opcode follows REQ-033.
REQ-023 Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111 and 1100111.
REQ-024 EXEC lasts one cycle; operand selection per class:
- LUI: A=2, B=1.
- AUIPC: A=1, B=1.
- OP: A=0, B=0.
- Other classes: A=0, B=1.
REQ-025 EXEC next state:
- LOAD, STORE: MEM.
- BRANCH: FETCH, with pc_write=1 and pc_src = branch_taken ? 1 : 0.
- All other classes: WB.
REQ-026 In MEM, dmem_req is held at 1 and dmem_we=1 for STORE only, until dmem_ready.
REQ-027 On dmem_ready in MEM: LOAD goes to WB; STORE goes to FETCH with pc_write=1 and pc_src=0.
REQ-028 WB lasts one cycle with reg_write=1 and pc_write=1, then goes to FETCH. Per class:
- LOAD: wb_sel=1, pc_src=0.
- JAL: wb_sel=2, pc_src=1.
- JALR: wb_sel=2, pc_src=2.
- All others: wb_sel=0, pc_src=0.
REQ-029 Minimum latencies: ALU instruction 4 cycles, branch 3, store 4, load 5, each assuming zero-wait memory.
REQ-030 Every memory wait cycle adds exactly one cycle; there is no timeout.

Reset
REQ-031 While rst_n=0: state=FETCH; trap=0; all request, write and strobe outputs=0; selects=0.
REQ-032 Reset asserted mid-operation aborts the current instruction immediately. imem_req rises on the first rising clk edge after rst_n deasserts, gated by a registered run flag.

Configuration
REQ-033 Macro ILLEGAL_TRAP_EN:
- Defined: an illegal opcode in DECODE enters TRAP, with trap=1 and all strobes 0. TRAP is left only by reset.
- Undefined: an illegal opcode is a NOP. DECODE goes directly to FETCH with pc_write=1, pc_src=0 and retire=1; trap is tied to 0.

Verification
REQ-034 Reset, then OP-IMM (0x00100093), zero-wait memories -> state sequence 0,1,2,4,0; imm_sel=0 in DECODE; reg_write=1 and retire=1 only in WB.
REQ-035 LOAD 0x00002083 with dmem_ready delayed 3 cycles -> dmem_req=1 for 4 cycles, dmem_we=0, wb_sel=1 in WB, total 8 cycles.
REQ-036 BRANCH 0x00000463 with branch_taken=1, then again with branch_taken=0 -> pc_write in EXEC with pc_src=1, then pc_src=0; reg_write never asserted.
REQ-037 JALR 0x000080E7 -> imm_sel=0; in WB wb_sel=2 and pc_src=2.
REQ-038 Opcode 0x7F: with ILLEGAL_TRAP_EN -> state=5 and trap=1 held for 20 cycles, cleared by rst_n=0. Without the macro -> retire pulse at the DECODE cycle, then FETCH.
REQ-039 rst_n pulsed low during MEM with dmem_req=1 -> dmem_req=0 asynchronously, state=0, imem_req=1 one edge after release.
